// File: rtl/sha_arbiter.sv
// Round-robin arbiter sharing one SHA256 core between NUM_REQ requesters, grant locked per message.
// Optional mid-message idle timeout abort: define SHA_ARB_TIMEOUT_EN.
module sha_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int BLOCK_W  = 512,
  parameter int DIGEST_W = 256,
  parameter int TIMEOUT  = 1024
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*BLOCK_W-1:0]   req_block,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DIGEST_W-1:0]          rsp_digest,
  output logic                         abort_irq,
  output logic [BLOCK_W-1:0]           sha_block,
  output logic                         sha_init,
  output logic                         sha_next,
  input  logic                         sha_ready,
  input  logic [DIGEST_W-1:0]          sha_digest,
  input  logic                         sha_digest_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GAP, S_WAIT, S_RESP} state_t;

  state_t               state, state_nxt;
  logic [NUM_REQ-1:0]   grant_q;
  logic [IDX_W-1:0]     owner_q, rr_ptr_q, owner_inc;
  logic                 first_q, last_q;
  logic [DIGEST_W-1:0]  digest_q;
  logic [IDX_W:0]       pick;
  logic                 accept, core_done, timeout_hit, abort_now;

  // First requesting index at or after ptr (with wrap); MSB flags a hit.
  function automatic logic [IDX_W:0] pick_rr(input logic [NUM_REQ-1:0] req,
                                              input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  assign pick      = pick_rr(req_valid, rr_ptr_q);
  assign accept    = (state == S_ISSUE) && req_valid[owner_q] && sha_ready;
  assign core_done = sha_ready && sha_digest_valid;
  assign owner_inc = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  assign grant      = grant_q;
  assign busy       = |grant_q;
  assign rsp_digest = digest_q;
  assign rsp_valid  = (state == S_RESP) ? grant_q : '0;
  assign abort_irq  = abort_now;

  always_comb begin
    sha_block = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_q[i]) sha_block = req_block[i*BLOCK_W +: BLOCK_W];
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    sha_init  = 1'b0;
    sha_next  = 1'b0;
    abort_now = 1'b0;
    case (state)
      S_IDLE:  if (pick[IDX_W]) state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (accept) begin
          req_ready[owner_q] = 1'b1;
          sha_init           = first_q;
          sha_next           = !first_q;
          state_nxt          = S_GAP;
        end else if (timeout_hit) begin
          abort_now = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      // Core ready drops a cycle late, so nothing is sampled here.
      S_GAP:   state_nxt = S_WAIT;
      S_WAIT:  if (core_done) state_nxt = last_q ? S_RESP : S_ISSUE;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= S_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      first_q  <= 1'b1;
      last_q   <= 1'b0;
      digest_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (pick[IDX_W]) begin
          grant_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick[IDX_W-1:0];
          owner_q <= pick[IDX_W-1:0];
          first_q <= 1'b1;
        end
        S_ISSUE: if (accept) begin
          last_q  <= req_last[owner_q];
          first_q <= 1'b0;
        end else if (abort_now) begin
          grant_q  <= '0;
          rr_ptr_q <= owner_inc;
          first_q  <= 1'b1;
        end
        // Captured on the edge into RESP so it is valid alongside rsp_valid.
        S_WAIT: if (core_done && last_q) digest_q <= sha_digest;
        S_RESP: begin
          grant_q  <= '0;
          rr_ptr_q <= owner_inc;
          first_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SHA_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] idle_cnt_q;
  logic             stall;

  assign stall       = (state == S_ISSUE) && !first_q && !req_valid[owner_q];
  assign timeout_hit = stall && (idle_cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)                          idle_cnt_q <= '0;
    else if (state != S_ISSUE || accept)  idle_cnt_q <= '0;
    else if (stall)                       idle_cnt_q <= idle_cnt_q + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: doc/sha_arbiter.md
Name: sha_arbiter

Overview:
- Shares the single SHA256 core in the minimum security module between NUM_REQ requesters (boot control, PCM, firmware mailbox, and similar).
- Round-robin grant, locked for a whole multi-block message.
- Sequences sha_init for the first block and sha_next for each later block.
- Returns the final digest to the granted requester only.
- Sits between the requesters and the sha_top block/init/next/ready/digest_valid interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BLOCK_W, 512, message block width
DIGEST_W, 256, digest width
TIMEOUT, 1024, idle cycles tolerated in mid-message before abort (used only with the optional feature)

Ports:
clk  in  1  clock
nreset  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  requester i has a block on req_block slice i
req_last  in  NUM_REQ  the presented block is the final block of requester i's message
req_block  in  NUM_REQ*BLOCK_W  per-requester block; slice i is bits [i*BLOCK_W +: BLOCK_W]
req_ready  out  NUM_REQ  1-cycle pulse: block of requester i accepted
grant  out  NUM_REQ  one-hot current owner; all zero when idle
busy  out  1  a message is in progress
rsp_valid  out  NUM_REQ  1-cycle pulse: rsp_digest is valid for requester i
rsp_digest  out  DIGEST_W  last completed digest, held until the next completion
abort_irq  out  1  1-cycle pulse on timeout abort (tied 0 without the feature)
sha_block  out  BLOCK_W  block to the core (owner's slice; zero when idle)
sha_init  out  1  core init pulse
sha_next  out  1  core next pulse
sha_ready  in  1  core idle
sha_digest  in  DIGEST_W  core digest
sha_digest_valid  in  1  core digest valid

Behaviour:
- Reset (nreset low, asynchronous): state IDLE; grant=0, busy=0, req_ready=0, rsp_valid=0, rsp_digest=0, sha_init=0, sha_next=0, abort_irq=0, first-flag=1, rr pointer=0 (requester 0 highest priority).
- States: IDLE, ISSUE, GAP, WAIT, RESP.
- IDLE:
  - If any req_valid, pick the first set bit searching from the rr pointer upward with wrap.
  - Register grant one-hot, busy=1, first-flag=1; go to ISSUE next cycle.
  - Losers are not acknowledged and must hold their requests.
- ISSUE:
  - When req_valid[owner] && sha_ready, in the same cycle:
    - pulse sha_init if first-flag, else sha_next;
    - pulse req_ready[owner];
    - latch req_last[owner]; clear first-flag; go to GAP.
  - Otherwise stay in ISSUE.
  - sha_block is combinationally the owner's slice whenever grant is non-zero.
  - Requests from non-owners are ignored while a grant is held.
- GAP: one cycle; sha_ready and sha_digest_valid are not sampled (core ready deasserts late). Go to WAIT.
- WAIT: wait for sha_ready && sha_digest_valid.
  - If latched last=1, go to RESP.
  - Otherwise go to ISSUE for the next block, keeping the grant.
- RESP (one cycle):
  - Register sha_digest into rsp_digest; pulse rsp_valid[owner].
  - Clear grant and busy; rr pointer = owner+1 mod NUM_REQ; go to IDLE.
- Latency:
  - req_valid in IDLE at cycle T, core ready: sha_init and req_ready at T+1.
  - Digest valid first seen in WAIT at cycle D: rsp_valid at D+1.
  - Single-block message with core latency L from the init pulse: rsp_valid at T+1+L+1 minimum.
- Simultaneous requests: exactly one grant. With all NUM_REQ requesting continuously, the grant order is 0,1,2,3,0,...
- Owner drops req_valid mid-message: the grant is held in ISSUE indefinitely (without the feature); no other requester is served.
- Owner presents req_last with its first block: single-block message, init only.
- rsp_digest is never updated except in RESP, so a requester can never read another requester's in-progress state.
- Reset asserted mid-operation: immediate return to reset values. The core is not reset by this block; the next grant always begins with sha_init.

Optional Feature:
- Macro SHA_ARB_TIMEOUT_EN.
- With the macro:
  - A counter counts cycles spent in ISSUE with first-flag=0 and req_valid[owner]=0; it clears on any accepted block.
  - When the count reaches TIMEOUT, the message is aborted: pulse abort_irq, no rsp_valid, rsp_digest unchanged.
  - The grant is cleared, the rr pointer advances past the owner, and the state goes to IDLE.
  - The owner's next request starts a new message with sha_init.
- Without the macro: no counter, abort_irq is constant 0, and the hold is unbounded.

Test Plan:
- Single requester 1, one block with req_last=1, core latency 64 -> sha_init and req_ready[1] one cycle after req_valid; rsp_valid[1] pulses once; rsp_digest equals the core digest; grant returns to 0.
- Requesters 0 and 2 assert together from reset, one block each -> 0 served first, then 2; grant never has two bits set.
- Requester 3 sends a 3-block message while 0 requests -> sha_init, sha_next, sha_next all for 3; 0 is granted only after rsp_valid[3].
- Four requesters held continuously for 8 messages -> grant order 0,1,2,3,0,1,2,3.
- Owner drops req_valid after block 1 of 2 with SHA_ARB_TIMEOUT_EN and TIMEOUT=16 -> abort_irq at the 16th idle cycle, no rsp_valid, waiting requester granted next.
- nreset pulsed low while in WAIT -> all outputs 0 immediately; the next request issues sha_init (not sha_next).
